// File: rtl/ctrl_pkg.sv
// Shared decode constants, control-bundle type and FSM encoding for the
// ID-stage EX control generator.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_RTYPE = 3'b101,
    ALU_PASSB = 3'b110
  } aluop_e;

  typedef enum logic [1:0] {
    SRC_RT    = 2'b00,
    SRC_SIMM  = 2'b01,
    SRC_ZIMM  = 2'b10,
    SRC_LUI   = 2'b11
  } alusrc_e;

  typedef enum logic [1:0] {
    DST_RT    = 2'b00,
    DST_RD    = 2'b01,
    DST_R31   = 2'b10
  } regdst_e;

  typedef struct packed {
    logic    altsrc;
    alusrc_e alusrc;
    regdst_e regdst;
    aluop_e  aluop;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into the EX control bundle, flagging
// opcodes the pipeline does not implement.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] instr,
  output ctrl_t         ctrl,
  output logic          illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.altsrc   = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
        ctrl.regdst   = DST_RD;
        ctrl.aluop    = ALU_RTYPE;
        ctrl.regwrite = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alusrc   = SRC_SIMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.regwrite = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alusrc   = SRC_SIMM;
        ctrl.aluop    = ALU_SLT;
        ctrl.regwrite = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alusrc   = SRC_ZIMM;
        ctrl.aluop    = ALU_AND;
        ctrl.regwrite = 1'b1;
      end
      OP_ORI: begin
        ctrl.alusrc   = SRC_ZIMM;
        ctrl.aluop    = ALU_OR;
        ctrl.regwrite = 1'b1;
      end
      OP_LUI: begin
        ctrl.alusrc   = SRC_LUI;
        ctrl.aluop    = ALU_PASSB;
        ctrl.regwrite = 1'b1;
      end
      OP_LW: begin
        ctrl.alusrc   = SRC_SIMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = SRC_SIMM;
        ctrl.aluop    = ALU_ADD;
        ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop    = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.regdst   = DST_R31;
        ctrl.aluop    = ALU_PASSB;
        ctrl.regwrite = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_gen.sv
// ID-stage producer of the ID/EX control register: decodes IF/ID, detects
// load-use hazards, stalls one cycle with an EX bubble, and honours flush.
module id_ex_ctrl_gen
  import ctrl_pkg::*;
#(
  parameter int IW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_valid,
  input  logic          flush,
  output logic          alualtsrcout,
  output logic [1:0]    alusrcout,
  output logic [1:0]    regdstout,
  output logic [2:0]    aluopout,
  output logic          regwriteout,
  output logic          memreadout,
  output logic          memwriteout,
  output logic          ex_validout,
  output logic          stall,
  output logic          illegal_op
);

  ctrl_t         dec_ctrl;
  logic          dec_illegal;
  ctrl_t         ctrl_reg;
  logic          ex_valid_reg;
  logic          illegal_reg;
  logic [RW-1:0] ex_rt_reg;
  state_e        state_reg;

  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic          hazard;
  logic          accept;
  logic          load_real;

  ctrl_decode #(.IW(IW)) u_decode (
    .instr   (instr_in),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign rs = instr_in[25:21];
  assign rt = instr_in[20:16];

  assign hazard = ctrl_reg.memread & ex_valid_reg & instr_valid & (ex_rt_reg != '0) &
                  ((ex_rt_reg == rs) | ((ex_rt_reg == rt) & reads_rt(instr_in[31:26])));

  // In BUBBLE the EX slot is already empty, so only RUN can raise a stall.
  assign stall     = (state_reg == ST_RUN) & hazard & ~flush;
  assign accept    = instr_valid & ~flush & ~stall;
  assign load_real = accept & ~dec_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg     <= CTRL_BUBBLE;
      ex_valid_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      ex_rt_reg    <= '0;
      state_reg    <= ST_RUN;
    end else begin
      ctrl_reg     <= load_real ? dec_ctrl : CTRL_BUBBLE;
      ex_valid_reg <= load_real;
      illegal_reg  <= accept & dec_illegal;
      ex_rt_reg    <= load_real ? rt : '0;
      case (state_reg)
        ST_RUN:    state_reg <= stall ? ST_BUBBLE : ST_RUN;
        ST_BUBBLE: state_reg <= ST_RUN;
        default:   state_reg <= ST_RUN;
      endcase
    end
  end

  assign alualtsrcout = ctrl_reg.altsrc;
  assign alusrcout    = ctrl_reg.alusrc;
  assign regdstout    = ctrl_reg.regdst;
  assign aluopout     = ctrl_reg.aluop;
  assign regwriteout  = ctrl_reg.regwrite;
  assign memreadout   = ctrl_reg.memread;
  assign memwriteout  = ctrl_reg.memwrite;
  assign ex_validout  = ex_valid_reg;
  assign illegal_op   = illegal_reg;

endmodule

// File: tb/tb_id_ex_ctrl_gen.sv
// Self-checking bench for id_ex_ctrl_gen: directed scenarios plus a randomized
// run against a table-driven model of the EX slot.
module tb_id_ex_ctrl_gen;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        flush;
  logic        alualtsrcout;
  logic [1:0]  alusrcout;
  logic [1:0]  regdstout;
  logic [2:0]  aluopout;
  logic        regwriteout;
  logic        memreadout;
  logic        memwriteout;
  logic        ex_validout;
  logic        stall;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

  // Model of the EX slot: bundle is {alt, src[1:0], dst[1:0], aluop[2:0], rw, mr, mw}
  logic [10:0] m_ctrl;
  logic        m_valid;
  logic [4:0]  m_rt;
  logic        m_ill;

  logic        exp_stall, obs_stall;
  logic [10:0] obs_ctrl;
  logic        obs_valid, obs_ill;

  id_ex_ctrl_gen #(.IW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .flush        (flush),
    .alualtsrcout (alualtsrcout),
    .alusrcout    (alusrcout),
    .regdstout    (regdstout),
    .aluopout     (aluopout),
    .regwriteout  (regwriteout),
    .memreadout   (memreadout),
    .memwriteout  (memwriteout),
    .ex_validout  (ex_validout),
    .stall        (stall),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ref_decode(input logic [31:0] ins, output logic legal);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    legal = 1'b1;
    case (op)
      6'h00:   return (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 11'b1_00_01_101_1_0_0
                                                                  : 11'b0_00_01_101_1_0_0;
      6'h08:   return 11'b0_01_00_000_1_0_0;
      6'h0A:   return 11'b0_01_00_100_1_0_0;
      6'h0C:   return 11'b0_10_00_010_1_0_0;
      6'h0D:   return 11'b0_10_00_011_1_0_0;
      6'h0F:   return 11'b0_11_00_110_1_0_0;
      6'h23:   return 11'b0_01_00_000_1_1_0;
      6'h2B:   return 11'b0_01_00_000_0_0_1;
      6'h04:   return 11'b0_00_00_001_0_0_0;
      6'h03:   return 11'b0_00_10_110_1_0_0;
      default: begin legal = 1'b0; return 11'b0; end
    endcase
  endfunction

  function automatic logic model_hazard(input logic [31:0] ins, input logic v);
    logic [4:0] rs, rt;
    logic       uses_rt;
    rs = ins[25:21];
    rt = ins[20:16];
    uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    return m_valid && m_ctrl[1] && v && (m_rt != 5'd0) &&
           ((m_rt == rs) || (m_rt == rt && uses_rt));
  endfunction

  task automatic model_reset();
    m_ctrl  = 11'b0;
    m_valid = 1'b0;
    m_rt    = 5'd0;
    m_ill   = 1'b0;
  endtask

  task automatic capture();
    obs_ctrl  = {alualtsrcout, alusrcout, regdstout, aluopout, regwriteout, memreadout, memwriteout};
    obs_valid = ex_validout;
    obs_ill   = illegal_op;
  endtask

  // Drives one ID cycle from posedge+1; samples stall mid-cycle, outputs at next posedge+1.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl);
    logic [10:0] d;
    logic        legal;
    logic        take;
    instr_in    = ins;
    instr_valid = v;
    flush       = fl;
    #3;
    exp_stall = model_hazard(ins, v) && !fl;
    obs_stall = stall;
    @(posedge clk);
    #1;
    d    = ref_decode(ins, legal);
    take = v && !fl && !exp_stall;
    m_ctrl  = (take && legal) ? d : 11'b0;
    m_valid = take && legal;
    m_rt    = (take && legal) ? ins[20:16] : 5'd0;
    m_ill   = take && !legal;
    capture();
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_in = 32'h0; instr_valid = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    capture();
    checks++;
    if (obs_ctrl !== 11'b0 || obs_valid !== 1'b0 || obs_ill !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%b valid=%b ill=%b stall=%b want all 0", obs_ctrl, obs_valid, obs_ill, stall);
    end
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    step(32'h20080005, 1'b1, 1'b0);
    checks++;
    if (obs_ctrl !== 11'b0_01_00_000_1_0_0 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_addi: ctrl=%b valid=%b want 00100000100 valid=1", obs_ctrl, obs_valid);
    end
    // Reset asserted while a load-use stall is being raised.
    step(32'h8D280000, 1'b1, 1'b0);
    instr_in = 32'h010B5020; instr_valid = 1'b1; flush = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_prestall: stall=%b want 1", stall);
    end
    rst = 1'b1;
    #1;
    capture();
    checks++;
    if (stall !== 1'b0 || obs_ctrl !== 11'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midstall: stall=%b ctrl=%b valid=%b want 0/0/0", stall, obs_ctrl, obs_valid);
    end
    instr_valid = 1'b0;
    model_reset();
    #2; rst = 1'b0;
    @(posedge clk); #1;
    // After reset the held add decodes normally, no stall.
    step(32'h010B5020, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || obs_ctrl !== m_ctrl || obs_valid !== m_valid) begin
      errors++;
      $display("FAIL reset_resume: stall=%b ctrl=%b valid=%b want 0 %b %b", obs_stall, obs_ctrl, obs_valid, m_ctrl, m_valid);
    end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    step(32'h8D280000, 1'b1, 1'b0);
    checks++;
    if (obs_ctrl !== m_ctrl || memreadout !== 1'b1) begin
      errors++;
      $display("FAIL lu_lw: ctrl=%b want %b", obs_ctrl, m_ctrl);
    end
    step(32'h010B5020, 1'b1, 1'b0);
    stalls += obs_stall;
    checks++;
    if (obs_stall !== 1'b1 || obs_valid !== 1'b0 || obs_ctrl !== 11'b0) begin
      errors++;
      $display("FAIL lu_stall: stall=%b valid=%b ctrl=%b want 1 0 0", obs_stall, obs_valid, obs_ctrl);
    end
    step(32'h010B5020, 1'b1, 1'b0);
    stalls += obs_stall;
    checks++;
    if (regdstout !== 2'b01 || aluopout !== 3'b101 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL lu_add: regdst=%b aluop=%b valid=%b want 01 101 1", regdstout, aluopout, obs_valid);
    end
    checks++;
    if (stalls != 1) begin
      errors++;
      $display("FAIL lu_stall_len: stall cycles=%0d want 1", stalls);
    end
  endtask

  task automatic test_no_stall_sll();
    step(32'h8D280000, 1'b1, 1'b0);
    step(32'h000B5100, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || alualtsrcout !== 1'b1 || aluopout !== 3'b101 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL sll_nostall: stall=%b alt=%b aluop=%b valid=%b want 0 1 101 1", obs_stall, alualtsrcout, aluopout, obs_valid);
    end
  endtask

  task automatic test_rt_zero();
    step(32'h8D200000, 1'b1, 1'b0);
    step(32'h00005020, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || obs_valid !== 1'b1 || obs_ctrl !== m_ctrl) begin
      errors++;
      $display("FAIL rt0_nostall: stall=%b valid=%b ctrl=%b want 0 1 %b", obs_stall, obs_valid, obs_ctrl, m_ctrl);
    end
  endtask

  task automatic test_flush();
    step(32'h8D280000, 1'b1, 1'b0);
    step(32'h010B5020, 1'b1, 1'b1);
    checks++;
    if (obs_stall !== 1'b0 || obs_valid !== 1'b0 || obs_ctrl !== 11'b0) begin
      errors++;
      $display("FAIL flush_prio: stall=%b valid=%b ctrl=%b want 0 0 0", obs_stall, obs_valid, obs_ctrl);
    end
    step(32'h010B5020, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || obs_valid !== 1'b1 || regdstout !== 2'b01 || aluopout !== 3'b101) begin
      errors++;
      $display("FAIL flush_next: stall=%b valid=%b regdst=%b aluop=%b want 0 1 01 101", obs_stall, obs_valid, regdstout, aluopout);
    end
  endtask

  task automatic test_illegal();
    step(32'hFC000000, 1'b1, 1'b0);
    checks++;
    if (obs_ill !== 1'b1 || obs_ctrl !== 11'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b ctrl=%b valid=%b want 1 0 0", obs_ill, obs_ctrl, obs_valid);
    end
    step(32'h3C011234, 1'b1, 1'b0);
    checks++;
    if (obs_ill !== 1'b0 || alusrcout !== 2'b11 || aluopout !== 3'b110 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_lui: ill=%b alusrc=%b aluop=%b valid=%b want 0 11 110 1", obs_ill, alusrcout, aluopout, obs_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(32'h8D280000, 1'b1, 1'b0);
    step(32'h8D090000, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall1: stall=%b want 1", obs_stall);
    end
    step(32'h8D090000, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || memreadout !== 1'b1 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lw2: stall=%b memread=%b valid=%b want 0 1 1", obs_stall, memreadout, obs_valid);
    end
    step(32'hAC090000, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b1 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall2: stall=%b valid=%b want 1 0", obs_stall, obs_valid);
    end
    step(32'hAC090000, 1'b1, 1'b0);
    checks++;
    if (obs_stall !== 1'b0 || memwriteout !== 1'b1 || regwriteout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sw: stall=%b memwrite=%b regwrite=%b want 0 1 0", obs_stall, memwriteout, regwriteout);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [12];
    logic [5:0]  fns [5];
    logic [31:0] ins;
    logic        v, fl;
    ops = '{6'h00, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22};
    ins = 32'h0;
    exp_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall) begin
        ins = {ops[$urandom_range(11)], 5'($urandom_range(3)), 5'($urandom_range(3)),
               5'($urandom), 5'($urandom), fns[$urandom_range(4)]};
      end
      v  = ($urandom_range(9) != 0);
      fl = ($urandom_range(9) == 0);
      step(ins, v, fl);
      checks++;
      if (obs_stall !== exp_stall || obs_ctrl !== m_ctrl || obs_valid !== m_valid || obs_ill !== m_ill) begin
        errors++;
        $display("FAIL rand[%0d] ins=%h v=%b fl=%b: stall=%b ctrl=%b valid=%b ill=%b want %b %b %b %b",
                 i, ins, v, fl, obs_stall, obs_ctrl, obs_valid, obs_ill, exp_stall, m_ctrl, m_valid, m_ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_sll();
    test_rt_zero();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_gen.md
Name: id_ex_ctrl_gen

Overview:
- Decode-stage producer of the EX control bundle for the pipeline EX control register: ALUAltSrc, ALUSrc[1:0], RegDst[1:0] and ALUOp[2:0], plus the MEM/WB control bits carried alongside them.
- Decodes the IF/ID instruction word and registers the bundle on each clock edge.
- Detects load-use hazards and resolves them by stalling fetch/decode and injecting a bubble.
- Honours a branch-resolution flush.

Parameters:
- IW, 32, instruction width.
- RW, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_in  in  IW  instruction from IF/ID.
- instr_valid  in  1  instr_in holds a real instruction.
- flush  in  1  branch taken in EX; squash the decoding instruction.
- alualtsrcout  out  1  0 = ALU A from rs, 1 = ALU A from shamt.
- alusrcout  out  2  ALU B select: 00 = rt, 01 = sign-ext imm, 10 = zero-ext imm, 11 = imm<<16.
- regdstout  out  2  destination select: 00 = rt, 01 = rd, 10 = reg 31.
- aluopout  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 R-type (funct decode in EX), 110 pass B.
- regwriteout  out  1  write-back enable.
- memreadout  out  1  load.
- memwriteout  out  1  store.
- ex_validout  out  1  EX slot holds a real instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- illegal_op  out  1  one-cycle pulse: an unsupported opcode was decoded.

Behaviour:
- Reset (async, immediate): all registered outputs 0, i.e. a bubble; internal ex_rt = 0; FSM = RUN; stall = 0.
- Latency: an instruction present in ID at edge N has its controls on the outputs after edge N.
- Decode table, giving altsrc/alusrc/regdst/aluop/regwrite/memread/memwrite:
  - R-type (op 0x00), funct not sll/srl/sra: 0/00/01/101/1/0/0.
  - sll/srl/sra (funct 0x00/0x02/0x03): 1/00/01/101/1/0/0.
  - addi 0x08: 0/01/00/000/1/0/0.
  - slti 0x0A: 0/01/00/100/1/0/0.
  - andi 0x0C: 0/10/00/010/1/0/0.
  - ori 0x0D: 0/10/00/011/1/0/0.
  - lui 0x0F: 0/11/00/110/1/0/0.
  - lw 0x23: 0/01/00/000/1/1/0.
  - sw 0x2B: 0/01/00/000/0/0/1.
  - beq 0x04: 0/00/00/001/0/0/0.
  - jal 0x03: 0/00/10/110/1/0/0.
  - Any other opcode: bubble (all 0), with illegal_op pulsed in the same cycle the outputs load.
- Load-use hazard (combinational):
  - hazard = memreadout & ex_validout & instr_valid & (ex_rt != 0) & (ex_rt == rs | (ex_rt == rt & instruction reads rt)).
  - Instructions that read rt: R-type, sw, beq.
- FSM:
  - RUN: if hazard and not flush → assert stall; load a bubble at the next edge; go to BUBBLE.
  - BUBBLE: stall = 0; the held instruction now decodes normally (the EX bubble has cleared the hazard); go to RUN.
- A second hazard can only arise from a new EX load, never from the bubble, so the stall never exceeds 1 cycle per load.
- flush has priority over hazard: load a bubble, stall = 0, FSM → RUN.
- instr_valid = 0 loads a bubble with no stall.
- ex_rt is registered from instr_in[20:16] only when a non-bubble is loaded; a bubble clears it to 0.
- Reset asserted mid-stall forces RUN, outputs a bubble, and deasserts stall immediately.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode and funct constants;
  - ALUOp, ALUSrc and RegDst encodings;
  - the bubble (all-zero) control bundle;
  - FSM state encoding.
- One sub-module, ctrl_decode: purely combinational, instr_in → control bundle plus illegal flag.
- The top level holds the hazard compare, the FSM and the output registers.

Test Plan:
- Reset with rst = 1 mid-run → all outputs 0 and stall = 0 asynchronously; after release, addi 0x20080005 valid → next edge gives alusrc = 01, regdst = 00, aluop = 000, regwrite = 1.
- lw 0x8D280000 followed by add 0x010B5020:
  - stall = 1 for exactly one cycle while add is in ID, and the EX slot gets a bubble (ex_validout = 0);
  - the following edge gives regdst = 01, aluop = 101.
- lw 0x8D280000 followed by sll 0x000B5100 (rt = 11 ≠ 8, no rs use) → no stall; alualtsrc = 1, aluop = 101.
- lw with rt = 0 (0x8D200000) followed by add reading $0 → no stall.
- Hazard with flush = 1 in the same cycle → stall = 0, bubble loaded, FSM in RUN; the next instruction decodes normally.
- Opcode 0x3F → illegal_op pulses 1 cycle and all controls are 0; then lui 0x3C011234 → alusrc = 11, aluop = 110.
